ping_pong_ctrl: RTL and testbench

//   Sequencer for one two-bank ping-pong buffer (the West or North instance)

---
 rtl/ping_pong_if.sv | 34 +++
 rtl/ping_pong_ctrl.sv | 99 +++++++++
 tb/tb_ping_pong_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ping_pong_if.sv
// Fill/drain handshake and memory address bundle of one ping-pong buffer sequencer.
// master is the controller's view; slave is the producer/memory/consumer side.
interface ping_pong_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_en;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  out_bank;
    logic [1:0]            bank_full;
    logic                  idle;

    modport master (
        input  in_valid, out_ready,
        output in_ready, wr_en, wr_bank, wr_addr,
        output rd_en, rd_bank, rd_addr,
        output out_valid, out_last, out_bank, bank_full, idle
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, wr_en, wr_bank, wr_addr,
        input  rd_en, rd_bank, rd_addr,
        input  out_valid, out_last, out_bank, bank_full, idle
    );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Two-bank ping-pong sequencer: fills one bank while the other drains to the array.
// Holds only addresses, bank pointers and full flags; the data lives in external memory.
module ping_pong_ctrl #(
    parameter int TOTAL_DEPTH = 8,
    parameter int ADDR_WIDTH  = $clog2(TOTAL_DEPTH)
) (
    input logic         clk,
    input logic         rst,
    ping_pong_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic                  wb_q, wb_d;
    logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                  rb_q, rb_d;
    logic [ADDR_WIDTH-1:0] rcnt_q, rcnt_d;
    logic [1:0]            full_q, full_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  out_bank_q, out_bank_d;

    logic in_ready;
    logic wr_en;
    logic rd_en;

    always_comb begin
        in_ready    = ~full_q[wb_q];
        wr_en       = bus.in_valid & in_ready;
        rd_en       = full_q[rb_q] & (~out_valid_q | bus.out_ready);

        wb_d        = wb_q;
        wcnt_d      = wcnt_q;
        rb_d        = rb_q;
        rcnt_d      = rcnt_q;
        full_d      = full_q;
        out_last_d  = out_last_q;
        out_bank_d  = out_bank_q;
        out_valid_d = rd_en | (out_valid_q & ~bus.out_ready);

        // Fill and drain completions always act on different banks, so both may apply.
        if (wr_en) begin
            if (wcnt_q == LAST_ADDR) begin
                wcnt_d       = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wcnt_d = wcnt_q + ADDR_ONE;
            end
        end

        if (rd_en) begin
            out_last_d = (rcnt_q == LAST_ADDR);
            out_bank_d = rb_q;
            if (rcnt_q == LAST_ADDR) begin
                rcnt_d       = '0;
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end else begin
                rcnt_d = rcnt_q + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= 1'b0;
            wcnt_q      <= '0;
            rb_q        <= 1'b0;
            rcnt_q      <= '0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_bank_q  <= 1'b0;
        end else begin
            wb_q        <= wb_d;
            wcnt_q      <= wcnt_d;
            rb_q        <= rb_d;
            rcnt_q      <= rcnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_bank_q  <= out_bank_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_bank   = wb_q;
    assign bus.wr_addr   = wcnt_q;
    assign bus.rd_en     = rd_en;
    assign bus.rd_bank   = rb_q;
    assign bus.rd_addr   = rcnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_bank  = out_bank_q;
    assign bus.bank_full = full_q;
    assign bus.idle      = ~full_q[0] & ~full_q[1] & ~out_valid_q & (wcnt_q == '0);
endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl: directed scenarios plus random traffic against a word-count model.
module tb_ping_pong_ctrl;
    localparam int D  = 8;
    localparam int AW = $clog2(D);

    logic clk;
    logic rst;

    ping_pong_if #(.ADDR_WIDTH(AW)) bus ();

    ping_pong_ctrl #(.TOTAL_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model: total words written / read since reset; banks follow from the counts.
    int W = 0;
    int R = 0;
    bit ov_m   = 0;
    bit last_m = 0;
    bit bank_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic ordy, input logic do_rst);
        int filled, wb, wcnt, rb, rcnt;
        logic [1:0] full_e;
        bit in_rdy_e, wr_en_e, rd_en_e, idle_e;
        @(negedge clk);
        rst           = do_rst;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        #1;
        cyc++;
        filled = W / D - R / D;
        wb     = (W / D) % 2;
        wcnt   = W % D;
        rb     = (R / D) % 2;
        rcnt   = R % D;
        full_e = 2'b00;
        if (filled >= 1) full_e[rb] = 1'b1;
        if (filled == 2) full_e = 2'b11;
        in_rdy_e = (filled < 2);
        wr_en_e  = iv && in_rdy_e;
        rd_en_e  = (filled > 0) && (!ov_m || ordy);
        idle_e   = (filled == 0) && !ov_m && (wcnt == 0);

        chk("in_ready",  32'(bus.in_ready),  32'(in_rdy_e));
        chk("wr_en",     32'(bus.wr_en),     32'(wr_en_e));
        chk("wr_bank",   32'(bus.wr_bank),   32'(wb));
        chk("wr_addr",   32'(bus.wr_addr),   32'(wcnt));
        chk("rd_en",     32'(bus.rd_en),     32'(rd_en_e));
        chk("rd_bank",   32'(bus.rd_bank),   32'(rb));
        chk("rd_addr",   32'(bus.rd_addr),   32'(rcnt));
        chk("out_valid", 32'(bus.out_valid), 32'(ov_m));
        chk("out_last",  32'(bus.out_last),  32'(last_m));
        chk("out_bank",  32'(bus.out_bank),  32'(bank_m));
        chk("bank_full", 32'(bus.bank_full), 32'(full_e));
        chk("idle",      32'(bus.idle),      32'(idle_e));

        if (do_rst) begin
            W = 0; R = 0; ov_m = 0; last_m = 0; bank_m = 0;
        end else begin
            if (wr_en_e) W++;
            if (rd_en_e) begin
                last_m = (rcnt == D - 1);
                bank_m = rb[0];
                R++;
            end
            ov_m = rd_en_e || (ov_m && !ordy);
        end
    endtask

    initial begin
        int piv, pordy;
        logic [AW-1:0] held_addr;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Fill bank 0, first read follows the fill, out_valid one cycle after that.
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        step(0, 1, 0);
        chk("t1_full01", 32'(bus.bank_full), 32'd1);
        chk("t1_rd_en",  32'(bus.rd_en),     32'd1);
        chk("t1_rd_addr", 32'(bus.rd_addr),  32'd0);
        step(0, 1, 0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) step(0, 1, 0);

        // Continuous streaming.
        step(0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            step(1, 1, 0);
            chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
        end
        for (int i = 0; i < 20; i++) step(0, 1, 0);

        // Consumer stall mid-bank.
        step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        held_addr = bus.rd_addr;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            chk("t3_rd_en", 32'(bus.rd_en), 32'd0);
            chk("t3_rd_addr", 32'(bus.rd_addr), 32'(held_addr + AW'(1)));
        end
        for (int i = 0; i < 15; i++) step(0, 1, 0);

        // Both banks full blocks the producer.
        step(0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        step(1, 0, 0);
        chk("t4_full11", 32'(bus.bank_full), 32'd3);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_wr_en", 32'(bus.wr_en), 32'd0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);

        // Last write of bank 1 coincides with last read of bank 0.
        step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        chk("t5_full10", 32'(bus.bank_full), 32'd2);
        chk("t5_wb", 32'(bus.wr_bank), 32'd0);
        chk("t5_rb", 32'(bus.rd_bank), 32'd1);
        for (int i = 0; i < 12; i++) step(0, 1, 0);

        // Reset in the middle of a fill and a drain.
        step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        step(1, 1, 1);
        step(1, 1, 0);
        chk("t6_wr_en", 32'(bus.wr_en), 32'd1);
        chk("t6_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("t6_wr_bank", 32'(bus.wr_bank), 32'd0);
        chk("t6_full", 32'(bus.bank_full), 32'd0);
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic with varying producer/consumer pressure and rare resets.
        for (int seg = 0; seg < 15; seg++) begin
            piv   = $urandom_range(10, 100);
            pordy = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++)
                step(($urandom_range(0, 99) < piv), ($urandom_range(0, 99) < pordy),
                     ($urandom_range(0, 499) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
